// File: rtl/mux_pkg.sv
// Shared definitions for the registered scanning multiplexer: mode
// encodings and the width helpers used to size select and dwell counters.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of a field that must hold 0..count-1, never narrower than one bit.
  function automatic int field_width(input int count);
    int r;
    r = clog2(count);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Host-side bundle of the scanning multiplexer: the control inputs, the
// flattened channel bank and the registered results. The host owns the
// master modport, the multiplexer the slave modport.
interface mux_scan_reg_if
  import mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
);

  localparam int SEL_W = field_width(N);

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic [N*W-1:0]   din;
  logic [W-1:0]     dout;
  logic [SEL_W-1:0] sel_out;
  logic             chg;
  logic             err;

  modport master (
    output en, mode, sel_in, din,
    input  dout, sel_out, chg, err
  );

  modport slave (
    input  en, mode, sel_in, din,
    output dout, sel_out, chg, err
  );

endinterface

// File: rtl/scan_sel_ctrl.sv
// Channel selection controller. Decides which channel drives the output on
// the next edge (sel_nxt), either from the host select or from a round-robin
// dwell counter, and keeps the registered select, change strobe and
// illegal-select flag.
module scan_sel_ctrl
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [field_width(N)-1:0] sel_in,
  output logic [field_width(N)-1:0] sel_nxt,
  output logic [field_width(N)-1:0] sel_out,
  output logic                    chg,
  output logic                    err
);

  localparam int SEL_W = field_width(N);
  localparam int CNT_W = field_width(DWELL + 1);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_nxt;
  logic             sel_legal;

  assign sel_legal = ({1'b0, sel_in} < N_EXT);

  // Next-select decision: host select in manual mode (illegal selects hold
  // the current channel), dwell-counted round-robin with explicit wrap at
  // N-1 in scan mode so non-power-of-two N never visits unused codes.
  always_comb begin
    sel_nxt = sel_out;
    cnt_nxt = cnt;
    err_nxt = err;
    if (mode == MODE_SCAN) begin
      if (cnt == LAST_CNT) begin
        cnt_nxt = '0;
        sel_nxt = (sel_out == LAST_SEL) ? '0 : sel_out + SEL_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      cnt_nxt = '0;
      if (sel_legal) begin
        sel_nxt = sel_in;
        err_nxt = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // Registered select state; en low freezes everything and suppresses chg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_out <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      chg     <= 1'b0;
    end else if (en) begin
      sel_out <= sel_nxt;
      cnt     <= cnt_nxt;
      err     <= err_nxt;
      chg     <= (sel_nxt != sel_out);
    end else begin
      chg     <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-channel, W-bit multiplexer with manual and round-robin scan
// modes. The select controller chooses the channel; this level extracts
// that channel from the flattened bank and registers it on the same edge
// the select is registered, so dout and sel_out always describe each other.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DWELL = 16
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_reg_if.slave bus
);

  localparam int SEL_W = field_width(N);

  logic [SEL_W-1:0] sel_nxt;
  logic [W-1:0]     ch_data;

  scan_sel_ctrl #(
    .N     (N),
    .DWELL (DWELL)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.en),
    .mode    (bus.mode),
    .sel_in  (bus.sel_in),
    .sel_nxt (sel_nxt),
    .sel_out (bus.sel_out),
    .chg     (bus.chg),
    .err     (bus.err)
  );

  // Channel extraction for the select that will be registered this edge.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_nxt == SEL_W'(k)) ch_data = bus.din[k*W +: W];
    end
  end

  // Output data register, held while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout <= '0;
    end else if (bus.en) begin
      bus.dout <= ch_data;
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed self-checking bench for mux_scan_reg. Three instances share one
// clock and reset: N=4/DWELL=4, N=3/DWELL=4 and N=4/DWELL=1.
module tb_mux_scan_reg;

  logic clk;
  logic rst_n;

  int checksTotal;
  int checksPassed;

  logic [7:0] d3 [3];
  logic [7:0] d1 [4];

  mux_scan_reg_if #(.W(8), .N(4)) b4 ();
  mux_scan_reg_if #(.W(8), .N(3)) b3 ();
  mux_scan_reg_if #(.W(8), .N(4)) b1 ();

  mux_scan_reg #(.W(8), .N(4), .DWELL(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  mux_scan_reg #(.W(8), .N(3), .DWELL(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  mux_scan_reg #(.W(8), .N(4), .DWELL(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive en/mode/sel_in of one instance (4, 3 or 1) and clock one edge.
  task automatic applyStimulus(input int which, input logic e, input logic m,
                               input logic [3:0] s);
    case (which)
      4: begin b4.en = e; b4.mode = m; b4.sel_in = s[1:0]; end
      3: begin b3.en = e; b3.mode = m; b3.sel_in = s[1:0]; end
      default: begin b1.en = e; b1.mode = m; b1.sel_in = s[1:0]; end
    endcase
    tick();
  endtask

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checksTotal++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      checksPassed++;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    d3 = '{8'h11, 8'h22, 8'h33};
    d1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rst_n = 1'b0;
    b4.en = 1'b1; b4.mode = 1'b0; b4.sel_in = '0; b4.din = 32'h44332211;
    b3.en = 1'b1; b3.mode = 1'b0; b3.sel_in = '0; b3.din = 24'h332211;
    b1.en = 1'b1; b1.mode = 1'b0; b1.sel_in = '0; b1.din = 32'hDDCCBBAA;

    tick();
    tick();
    checkOutput("rst_dout",    32'(b4.dout),    32'h0);
    checkOutput("rst_sel_out", 32'(b4.sel_out), 32'h0);
    checkOutput("rst_chg",     32'(b4.chg),     32'h0);
    checkOutput("rst_err",     32'(b4.err),     32'h0);
    rst_n = 1'b1;

    $display("[TB] manual select, N=4");
    applyStimulus(4, 1'b1, 1'b0, 4'd2);
    checkOutput("man_dout",    32'(b4.dout),    32'h33);
    checkOutput("man_sel_out", 32'(b4.sel_out), 32'h2);
    checkOutput("man_chg",     32'(b4.chg),     32'h1);
    checkOutput("man_err",     32'(b4.err),     32'h0);
    applyStimulus(4, 1'b1, 1'b0, 4'd2);
    checkOutput("man_hold_chg", 32'(b4.chg),    32'h0);

    $display("[TB] asynchronous reset mid-cycle");
    b4.din = 32'h44A52211;
    applyStimulus(4, 1'b1, 1'b0, 4'd2);
    checkOutput("pre_rst_dout", 32'(b4.dout),   32'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_dout",    32'(b4.dout),    32'h0);
    checkOutput("async_sel_out", 32'(b4.sel_out), 32'h0);
    checkOutput("async_chg",     32'(b4.chg),     32'h0);
    checkOutput("async_err",     32'(b4.err),     32'h0);
    #1;
    rst_n = 1'b1;
    b4.din = 32'h44332211;

    $display("[TB] mode switch scan->manual->scan, N=4 DWELL=4");
    applyStimulus(4, 1'b1, 1'b0, 4'd1);
    checkOutput("ms_sel1",  32'(b4.sel_out), 32'h1);
    checkOutput("ms_chg1",  32'(b4.chg),     32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(4, 1'b1, 1'b1, 4'd1);
    checkOutput("ms_cnt3_sel", 32'(b4.sel_out), 32'h1);
    checkOutput("ms_cnt3_chg", 32'(b4.chg),     32'h0);
    applyStimulus(4, 1'b1, 1'b0, 4'd3);
    checkOutput("ms_man_sel",  32'(b4.sel_out), 32'h3);
    checkOutput("ms_man_dout", 32'(b4.dout),    32'h44);
    checkOutput("ms_man_chg",  32'(b4.chg),     32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(4, 1'b1, 1'b1, 4'd0);
    checkOutput("ms_dwell_sel", 32'(b4.sel_out), 32'h3);
    checkOutput("ms_dwell_chg", 32'(b4.chg),     32'h0);
    applyStimulus(4, 1'b1, 1'b1, 4'd0);
    checkOutput("ms_wrap_sel",  32'(b4.sel_out), 32'h0);
    checkOutput("ms_wrap_dout", 32'(b4.dout),    32'h11);
    checkOutput("ms_wrap_chg",  32'(b4.chg),     32'h1);
    b4.mode = 1'b0;

    $display("[TB] illegal select, N=3");
    applyStimulus(3, 1'b1, 1'b0, 4'd1);
    checkOutput("ill_pre_sel", 32'(b3.sel_out), 32'h1);
    checkOutput("ill_pre_err", 32'(b3.err),     32'h0);
    applyStimulus(3, 1'b1, 1'b0, 4'd3);
    checkOutput("ill_sel",  32'(b3.sel_out), 32'h1);
    checkOutput("ill_dout", 32'(b3.dout),    32'h22);
    checkOutput("ill_err",  32'(b3.err),     32'h1);
    checkOutput("ill_chg",  32'(b3.chg),     32'h0);
    applyStimulus(3, 1'b1, 1'b0, 4'd0);
    checkOutput("rec_err",  32'(b3.err),     32'h0);
    checkOutput("rec_sel",  32'(b3.sel_out), 32'h0);
    checkOutput("rec_chg",  32'(b3.chg),     32'h1);
    checkOutput("rec_dout", 32'(b3.dout),    32'h11);

    $display("[TB] scan wrap, N=3 DWELL=4");
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(3, 1'b1, 1'b1, 4'd3);
      checkOutput("scan_sel",  32'(b3.sel_out), 32'((e / 4) % 3));
      checkOutput("scan_chg",  32'(b3.chg),     32'((e % 4) == 0));
      checkOutput("scan_dout", 32'(b3.dout),    32'(d3[(e / 4) % 3]));
    end
    checkOutput("scan_err_held", 32'(b3.err), 32'h0);

    $display("[TB] enable freeze, N=3 DWELL=4");
    applyStimulus(3, 1'b1, 1'b1, 4'd3);
    applyStimulus(3, 1'b1, 1'b1, 4'd3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3, 1'b0, 1'b1, 4'd3);
      checkOutput("frz_sel",  32'(b3.sel_out), 32'h0);
      checkOutput("frz_dout", 32'(b3.dout),    32'h11);
      checkOutput("frz_chg",  32'(b3.chg),     32'h0);
    end
    applyStimulus(3, 1'b1, 1'b1, 4'd3);
    checkOutput("thaw1_sel", 32'(b3.sel_out), 32'h0);
    checkOutput("thaw1_chg", 32'(b3.chg),     32'h0);
    applyStimulus(3, 1'b1, 1'b1, 4'd3);
    checkOutput("thaw2_sel",  32'(b3.sel_out), 32'h1);
    checkOutput("thaw2_chg",  32'(b3.chg),     32'h1);
    checkOutput("thaw2_dout", 32'(b3.dout),    32'h22);

    $display("[TB] DWELL=1 advances every cycle, N=4");
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(1, 1'b1, 1'b1, 4'd0);
      checkOutput("dw1_sel",  32'(b1.sel_out), 32'(e % 4));
      checkOutput("dw1_dout", 32'(b1.dout),    32'(d1[e % 4]));
      checkOutput("dw1_chg",  32'(b1.chg),     32'h1);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
